// File: rtl/sprite_pkg.sv
// Shared constants, state/request encodings and the per-axis bounce helper
// for the sprite motion controller.
package sprite_pkg;

  localparam logic [10:0] H_DISPLAY    = 11'd640;
  localparam logic [10:0] V_DISPLAY    = 11'd480;
  localparam logic [9:0]  SPRITE_CELLS = 10'd16;
  localparam logic [4:0]  SIZE_MIN     = 5'd1;
  localparam logic [4:0]  SIZE_MAX     = 5'd30;
  localparam logic [4:0]  SIZE_INIT    = 5'd10;

  localparam logic signed [10:0] STEP_POS   = 11'sd2;
  localparam logic signed [10:0] STEP_NEG   = -11'sd2;
  localparam logic signed [10:0] POS_X_INIT = 11'sd240;
  localparam logic signed [10:0] POS_Y_INIT = 11'sd160;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_APPLY,
    ST_MOVE,
    ST_CLAMP,
    ST_PUBLISH
  } state_e;

  typedef enum logic [1:0] {
    REQ_NONE,
    REQ_INC,
    REQ_DEC
  } req_e;

  // Bounce one axis off the far edge or the origin. When the sprite exactly
  // fills the axis, the position is pinned at 0 and the direction flips each
  // frame because the moved position lands on +STEP or -STEP alternately.
  function automatic void clamp_axis(
    input  logic signed [10:0] pos_in,
    input  logic signed [10:0] dir_in,
    input  logic [9:0]         extent,
    input  logic [10:0]        display,
    output logic signed [10:0] pos_out,
    output logic signed [10:0] dir_out
  );
    logic signed [10:0] ext_s;
    logic signed [10:0] disp_s;
    ext_s   = $signed({1'b0, extent});
    disp_s  = $signed(display);
    pos_out = pos_in;
    dir_out = dir_in;
    if (pos_in + ext_s > disp_s) begin
      pos_out = disp_s - ext_s;
      dir_out = STEP_NEG;
    end else if (pos_in < 11'sd0) begin
      pos_out = 11'sd0;
      dir_out = STEP_POS;
    end
  endfunction

endpackage

// File: rtl/button_debounce.sv
// Slow-sample debouncer: buttons are sampled once per counter wrap, and a
// rising edge of the sampled level yields a one-cycle press pulse.
module button_debounce #(
  parameter int N             = 2,
  parameter int DEBOUNCE_BITS = 19
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [N-1:0] button_i,
  output logic [N-1:0] press_o
);

  logic [DEBOUNCE_BITS-1:0] cnt_q;
  logic [N-1:0]             stable_q;
  logic [N-1:0]             prev_q;

  // Free-running sample counter, sampled level and its one-cycle delay.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q    <= '0;
      stable_q <= '0;
      prev_q   <= '0;
    end else begin
      cnt_q <= cnt_q + {{(DEBOUNCE_BITS-1){1'b0}}, 1'b1};
      if (cnt_q == '0) stable_q <= button_i;
      prev_q <= stable_q;
    end
  end

  assign press_o = stable_q & ~prev_q;

endmodule

// File: rtl/sprite_motion.sv
// Per-frame sprite scale/position update with debounced scale buttons.
//
//  state      | meaning
//  -----------+----------------------------------------------------------
//  ST_IDLE    | waiting for FRAME_TICK; outputs hold
//  ST_APPLY   | apply pending scale request (saturating), clear request
//  ST_MOVE    | advance working position by current direction
//  ST_CLAMP   | bounce each axis off the active-area edges
//  ST_PUBLISH | copy working values to outputs, pulse UPDATED
module sprite_motion
  import sprite_pkg::*;
#(
  parameter int DEBOUNCE_BITS = 19
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [1:0] BUTTON,
  input  logic       FRAME_TICK,
  output logic [4:0] SIZE,
  output logic [9:0] POS_X,
  output logic [9:0] POS_Y,
  output logic       UPDATED
);

  state_e             state_q, state_d;
  req_e               req_q, req_d;
  logic [4:0]         size_q, size_d;
  logic signed [10:0] x_q, x_d, y_q, y_d;
  logic signed [10:0] dx_q, dx_d, dy_q, dy_d;
  logic               upd_d;
  logic [4:0]         size_out_q;
  logic [9:0]         pos_x_out_q, pos_y_out_q;
  logic               upd_q;
  logic [1:0]         press;
  logic [9:0]         extent;

  button_debounce #(
    .N            (2),
    .DEBOUNCE_BITS(DEBOUNCE_BITS)
  ) u_debounce (
    .clk_i   (CLK),
    .rst_i   (RESET),
    .button_i(BUTTON),
    .press_o (press)
  );

  assign extent = {5'b0, size_q} * SPRITE_CELLS;

  // Pending scale request: a new press beats the clear in APPLY, up beats down.
  always_comb begin
    req_d = req_q;
    if (state_q == ST_APPLY) req_d = REQ_NONE;
    if (press[0])      req_d = REQ_INC;
    else if (press[1]) req_d = REQ_DEC;
  end

  // Next-state and working-register update for the per-frame sequence.
  always_comb begin
    state_d = state_q;
    size_d  = size_q;
    x_d     = x_q;
    y_d     = y_q;
    dx_d    = dx_q;
    dy_d    = dy_q;
    upd_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (FRAME_TICK) state_d = ST_APPLY;
      end
      ST_APPLY: begin
        if (req_q == REQ_INC && size_q < SIZE_MAX)      size_d = size_q + 5'd1;
        else if (req_q == REQ_DEC && size_q > SIZE_MIN) size_d = size_q - 5'd1;
        state_d = ST_MOVE;
      end
      ST_MOVE: begin
        x_d     = x_q + dx_q;
        y_d     = y_q + dy_q;
        state_d = ST_CLAMP;
      end
      ST_CLAMP: begin
        clamp_axis(x_q, dx_q, extent, H_DISPLAY, x_d, dx_d);
        clamp_axis(y_q, dy_q, extent, V_DISPLAY, y_d, dy_d);
        state_d = ST_PUBLISH;
      end
      ST_PUBLISH: begin
        upd_d   = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, request and working registers.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= ST_IDLE;
      req_q   <= REQ_NONE;
      size_q  <= SIZE_INIT;
      x_q     <= POS_X_INIT;
      y_q     <= POS_Y_INIT;
      dx_q    <= STEP_POS;
      dy_q    <= STEP_POS;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      size_q  <= size_d;
      x_q     <= x_d;
      y_q     <= y_d;
      dx_q    <= dx_d;
      dy_q    <= dy_d;
    end
  end

  // Output registers change only on the publish cycle.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      size_out_q  <= SIZE_INIT;
      pos_x_out_q <= POS_X_INIT[9:0];
      pos_y_out_q <= POS_Y_INIT[9:0];
      upd_q       <= 1'b0;
    end else begin
      upd_q <= upd_d;
      if (state_q == ST_PUBLISH) begin
        size_out_q  <= size_q;
        pos_x_out_q <= x_q[9:0];
        pos_y_out_q <= y_q[9:0];
      end
    end
  end

  assign SIZE    = size_out_q;
  assign POS_X   = pos_x_out_q;
  assign POS_Y   = pos_y_out_q;
  assign UPDATED = upd_q;

endmodule
